// File: rtl/cdc_4phase_pkg.sv
// rtl/cdc_4phase_pkg.sv - shared state encoding for the 4-phase CDC receive end
package cdc_4phase_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_READY = 2'd1,
    ACK        = 2'd2
  } state_e;

endpackage

// File: rtl/cdc_sync_ah.sv
// rtl/cdc_sync_ah.sv - multi-flop 1-bit synchronizer, async active-high reset to 0
module cdc_sync_ah #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  (* dont_touch = "true" *) logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_4phase_dst_ah.sv
// rtl/cdc_4phase_dst_ah.sv - 4-phase req/ack receive end with valid/ready output
// Optional accepted-word counter on cnt_o when CDC_4PHASE_DST_CNT_EN is defined.
module cdc_4phase_dst_ah
  import cdc_4phase_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DECOUPLED   = 1,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  async_req_i,
  output logic                  async_ack_o,
  input  logic [DATA_WIDTH-1:0] async_data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
`ifdef CDC_4PHASE_DST_CNT_EN
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [CNT_WIDTH-1:0]  cnt_o
`else
  output logic [DATA_WIDTH-1:0] data_o
`endif
);

  state_e                state_q, state_d;
  logic                  ack_q, ack_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  req_s;
  logic                  pop;

  cdc_sync_ah #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (async_req_i),
    .q_o   (req_s)
  );

  assign pop = valid_q & ready_i;

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    valid_d = valid_q;
    data_d  = data_q;
    if (DECOUPLED != 0) begin
      // A capture may overlap the pop of the previous word: valid stays high.
      case (state_q)
        IDLE: begin
          if (req_s && (!valid_q || ready_i)) begin
            data_d  = async_data_i;
            valid_d = 1'b1;
            ack_d   = 1'b1;
            state_d = ACK;
          end else if (pop) begin
            valid_d = 1'b0;
          end
        end
        ACK: begin
          if (pop) valid_d = 1'b0;
          if (!req_s) begin
            ack_d   = 1'b0;
            state_d = IDLE;
          end
        end
        default: begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          if (req_s) begin
            data_d  = async_data_i;
            valid_d = 1'b1;
            state_d = WAIT_READY;
          end
        end
        WAIT_READY: begin
          if (ready_i) begin
            valid_d = 1'b0;
            ack_d   = 1'b1;
            state_d = ACK;
          end
        end
        ACK: begin
          if (!req_s) begin
            ack_d   = 1'b0;
            state_d = IDLE;
          end
        end
        default: begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign async_ack_o = ack_q;
  assign valid_o     = valid_q;
  assign data_o      = data_q;

`ifdef CDC_4PHASE_DST_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  assign cnt_d = pop ? cnt_q + CNT_WIDTH'(1) : cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_cdc_4phase_dst_ah.sv
// tb/tb_cdc_4phase_dst_ah.sv - scoreboard bench for both DECOUPLED modes of the 4-phase receive end
module tb_cdc_4phase_dst_ah;

  logic clk = 1'b0;
  logic sclk = 1'b0;
  logic rst = 1'b1;

  logic       req1 = 1'b0, req0 = 1'b0;
  logic [1:0] sd1 = '0, sd0 = '0;
  logic       ready1 = 1'b0, ready0 = 1'b0;
  wire        ack1, ack0, v1, v0;
  wire  [1:0] do1, do0;
`ifdef CDC_4PHASE_DST_CNT_EN
  wire [15:0] cnt1, cnt0;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int pops[2];
  logic [1:0] exp1[$];
  logic [1:0] exp0[$];
  logic       pv[2], pr[2];
  logic [1:0] pd[2];
  bit rnd_ready = 0;

  always #5 clk = ~clk;
  initial begin
    #1;
    forever #3 sclk = ~sclk;
  end

  cdc_4phase_dst_ah #(.DATA_WIDTH(2), .SYNC_STAGES(2), .DECOUPLED(1), .CNT_WIDTH(16)) dut1 (
    .clk_i(clk), .rst_i(rst), .async_req_i(req1), .async_ack_o(ack1),
    .async_data_i(sd1), .valid_o(v1), .ready_i(ready1),
`ifdef CDC_4PHASE_DST_CNT_EN
    .data_o(do1), .cnt_o(cnt1)
`else
    .data_o(do1)
`endif
  );

  cdc_4phase_dst_ah #(.DATA_WIDTH(2), .SYNC_STAGES(2), .DECOUPLED(0), .CNT_WIDTH(16)) dut0 (
    .clk_i(clk), .rst_i(rst), .async_req_i(req0), .async_ack_o(ack0),
    .async_data_i(sd0), .valid_o(v0), .ready_i(ready0),
`ifdef CDC_4PHASE_DST_CNT_EN
    .data_o(do0), .cnt_o(cnt0)
`else
    .data_o(do0)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic get_ack(input int sel);
    return (sel != 0) ? ack1 : ack0;
  endfunction

  task automatic set_req(input int sel, input logic val);
    if (sel != 0) req1 = val; else req0 = val;
  endtask

  task automatic send_start(input int sel, input logic [1:0] d);
    if (sel != 0) begin sd1 = d; exp1.push_back(d); end
    else begin sd0 = d; exp0.push_back(d); end
    set_req(sel, 1'b1);
  endtask

  task automatic wait_ack(input int sel, input logic val, input bit on_src, input string name);
    int n = 0;
    while (get_ack(sel) !== val && n < 200) begin
      if (on_src) @(posedge sclk); else begin @(posedge clk); #1; end
      n++;
    end
    if (get_ack(sel) !== val) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout, ack=%0b required %0b", name, get_ack(sel), val);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_one(input int sel, input logic v, input logic r, input logic [1:0] d);
    logic [1:0] e;
    if (rst) begin
      pv[sel] = 1'b0;
      pr[sel] = 1'b0;
      return;
    end
    if (pv[sel] && !pr[sel])
      check((sel != 0) ? "hold_stable_dec1" : "hold_stable_dec0", {31'd0, v, d}, {31'd0, 1'b1, pd[sel]});
    if (v && r) begin
      if (sel != 0 && exp1.size() == 0 || sel == 0 && exp0.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word dut%0d: got %0h expected none", sel, d);
      end else begin
        e = (sel != 0) ? exp1.pop_front() : exp0.pop_front();
        check((sel != 0) ? "word_dec1" : "word_dec0", {30'd0, d}, {30'd0, e});
      end
      pops[sel]++;
    end
    pv[sel] = v;
    pr[sel] = r;
    pd[sel] = d;
  endtask

  always @(negedge clk) begin
    mon_one(1, v1, ready1, do1);
    mon_one(0, v0, ready0, do0);
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) begin
        ready1 = 1'($urandom_range(0, 1));
        ready0 = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic src_stream(input int sel);
    for (int i = 0; i < 100; i++) begin
      @(posedge sclk);
      send_start(sel, 2'($urandom));
      wait_ack(sel, 1'b1, 1, "stream_ack_rise");
      @(posedge sclk);
      set_req(sel, 1'b0);
      wait_ack(sel, 1'b0, 1, "stream_ack_fall");
      repeat ($urandom_range(0, 3)) @(posedge sclk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, queues %0d %0d", exp1.size(), exp0.size());
    $fatal(1, "watchdog");
  end

  initial begin
    pops[0] = 0;
    pops[1] = 0;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {28'd0, v1, ack1, v0, ack0}, 32'd0);
    check("reset_data", {28'd0, do1, do0}, 32'd0);
`ifdef CDC_4PHASE_DST_CNT_EN
    check("reset_cnt", {cnt1, cnt0}, 32'd0);
`endif
    rst = 1'b0;
    ready1 = 1'b1;
    ready0 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      edge1();
      check("idle_after_reset", {24'd0, v1, ack1, v0, ack0, do1, do0}, 32'd0);
    end

    // Single word, decoupled, ready high: latency 3 edges in, 3 edges out
    send_start(1, 2'b10);
    edge1();
    check("lat_e1_valid", {31'd0, v1}, 32'd0);
    edge1();
    check("lat_e2_valid", {30'd0, v1, ack1}, 32'd0);
    edge1();
    check("lat_e3", {28'd0, v1, ack1, do1}, {28'd0, 2'b11, 2'b10});
    set_req(1, 1'b0);
    edge1();
    edge1();
    check("ackfall_e2", {31'd0, ack1}, 32'd1);
    edge1();
    check("ackfall_e3", {31'd0, ack1}, 32'd0);
`ifdef CDC_4PHASE_DST_CNT_EN
    check("cnt_single", {16'd0, cnt1}, 32'd1);
`endif

    // Backpressure with decoupled ack; pop and capture on the same edge
    ready1 = 1'b0;
    send_start(1, 2'b01);
    wait_ack(1, 1'b1, 0, "bp_first_ack");
    check("bp_first_held", {29'd0, v1, do1}, {29'd0, 1'b1, 2'b01});
    set_req(1, 1'b0);
    wait_ack(1, 1'b0, 0, "bp_first_ackfall");
    send_start(1, 2'b11);
    for (int i = 0; i < 6; i++) begin
      edge1();
      check("bp_second_blocked", {28'd0, ack1, v1, do1}, {28'd0, 2'b01, 2'b01});
    end
    ready1 = 1'b1;
    edge1();
    check("bp_pop_and_capture", {28'd0, ack1, v1, do1}, {28'd0, 2'b11, 2'b11});
    edge1();
    check("bp_drained", {31'd0, v1}, 32'd0);
    set_req(1, 1'b0);
    wait_ack(1, 1'b0, 0, "bp_second_ackfall");

    // Coupled mode: ack only after downstream accepts
    ready0 = 1'b0;
    send_start(0, 2'b11);
    repeat (3) edge1();
    check("c_valid_no_ack", {28'd0, ack0, v0, do0}, {28'd0, 2'b01, 2'b11});
    for (int i = 0; i < 10; i++) begin
      edge1();
      check("c_stall", {28'd0, ack0, v0, do0}, {28'd0, 2'b01, 2'b11});
    end
    ready0 = 1'b1;
    edge1();
    ready0 = 1'b0;
    check("c_ack_after_accept", {30'd0, ack0, v0}, {30'd0, 2'b10});
    set_req(0, 1'b0);
    wait_ack(0, 1'b0, 0, "c_ackfall");
`ifdef CDC_4PHASE_DST_CNT_EN
    check("cnt_coupled", {16'd0, cnt0}, 32'd1);
`endif

    // Reset while in ACK discards the word immediately
    ready1 = 1'b0;
    send_start(1, 2'b01);
    wait_ack(1, 1'b1, 0, "rst_pre_ack");
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_async", {30'd0, ack1, v1}, 32'd0);
`ifdef CDC_4PHASE_DST_CNT_EN
    check("rst_async_cnt", {16'd0, cnt1}, 32'd0);
`endif
    exp1.delete();
    exp0.delete();
    pops[0] = 0;
    pops[1] = 0;
    set_req(1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ready1 = 1'b1;
    ready0 = 1'b1;
    repeat (5) edge1();
    check("rst_back_idle", {28'd0, ack1, v1, ack0, v0}, 32'd0);

    // Random stream from an unrelated source clock, random downstream ready
    rnd_ready = 1;
    fork
      src_stream(1);
      src_stream(0);
    join
    for (int i = 0; i < 200 && (exp1.size() != 0 || exp0.size() != 0); i++) edge1();
    rnd_ready = 0;
    ready1 = 1'b1;
    ready0 = 1'b1;
    repeat (3) edge1();
    check("stream_leftover", exp1.size() + exp0.size(), 32'd0);
    check("stream_pops_dec1", pops[1], 32'd100);
    check("stream_pops_dec0", pops[0], 32'd100);
`ifdef CDC_4PHASE_DST_CNT_EN
    check("stream_cnt", {cnt1, cnt0}, {16'd100, 16'd100});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
